// File: rtl/waveform_to_pipe_bram_pkg.sv
// waveform_to_pipe_bram_pkg: shared state encoding and pipe-word constants
package waveform_to_pipe_bram_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        PREFETCH = 2'd2,
        FULL     = 2'd3
    } state_t;
    localparam logic HI_FIRST = 1'b0;
    localparam logic LO       = 1'b1;
    localparam int   PIPE_W   = 16;
endpackage

// File: rtl/waveform_to_pipe_bram_wave_capture_bram.sv
// wave_capture_bram: inferred simple dual-port RAM, 32 bits x 2**ADDR_WIDTH, synchronous read
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port (rdata valid one cycle after raddr).
module wave_capture_bram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/waveform_to_pipe_bram.sv
// waveform_to_pipe_bram: capture a burst of 32-bit samples into BRAM and drain it as 16-bit pipe-out words
// Ports: clk, reset_n (async, active low); arm starts a capture; sample_valid/sample_data feed it;
//   pipe_out_read consumes one half-word; pipe_out_data/ready present the stream (upper half first);
//   capturing, wr_addr, rd_addr are status/debug. Optional decim_ratio input when
//   WAVE_CAPTURE_DECIM_EN is defined: only every (decim_ratio+1)th valid sample is stored.
module waveform_to_pipe_bram
    import waveform_to_pipe_bram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   arm,
    input  logic                   sample_valid,
    input  logic [31:0]            sample_data,
    input  logic                   pipe_out_read,
`ifdef WAVE_CAPTURE_DECIM_EN
    input  logic [DECIM_WIDTH-1:0] decim_ratio,
`endif
    output logic [PIPE_W-1:0]      pipe_out_data,
    output logic                   ready,
    output logic                   capturing,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [ADDR_WIDTH:0]    rd_addr
);
    state_t                state, st_n;
    logic [ADDR_WIDTH-1:0] wa_n;
    logic [ADDR_WIDTH:0]   rd_nxt;
    logic [31:0]           rdata;
    logic [PIPE_W-1:0]     hold, half;
    logic                  we, take;

`ifdef WAVE_CAPTURE_DECIM_EN
    logic [DECIM_WIDTH-1:0] ratio, dcnt;
    assign take = dcnt == '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ratio <= '0;
            dcnt  <= '0;
        end else if (st_n == CAPTURE && state != CAPTURE) begin
            ratio <= decim_ratio;
            dcnt  <= '0;
        end else if (state == CAPTURE && sample_valid) begin
            dcnt  <= dcnt == ratio ? '0 : dcnt + DECIM_WIDTH'(1);
        end
    end
`else
    assign take = DECIM_WIDTH > 0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            wr_addr <= '0;
            rd_addr <= '0;
            hold    <= '0;
        end else begin
            state   <= st_n;
            wr_addr <= wa_n;
            rd_addr <= rd_nxt;
            hold    <= pipe_out_data;
        end
    end

    always_comb begin
        st_n = state;
        wa_n = wr_addr;
        we   = 1'b0;
        unique case (state)
            IDLE: if (arm) begin
                st_n = CAPTURE;
                wa_n = '0;
            end
            CAPTURE: if (sample_valid && take) begin
                we   = 1'b1;
                wa_n = wr_addr + ADDR_WIDTH'(1);
                if (wr_addr == '1) st_n = PREFETCH;
            end
            PREFETCH: st_n = FULL;
            FULL: if (arm) begin
                st_n = CAPTURE;
                wa_n = '0;
            end else if (pipe_out_read && rd_addr == '1) begin
                st_n = IDLE;
            end
        endcase
        // Pointer after this edge; the BRAM is addressed with it so rdata always holds the current word.
        rd_nxt = (state == FULL && !arm) ? rd_addr + (ADDR_WIDTH+1)'(pipe_out_read) : '0;
    end

    assign ready         = state == FULL;
    assign capturing     = state == CAPTURE;
    assign half          = rd_addr[0] == HI_FIRST ? rdata[31:16] : rdata[15:0];
    assign pipe_out_data = ready ? half : hold;

    wave_capture_bram #(.ADDR_WIDTH(ADDR_WIDTH)) u_bram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_addr),
        .wdata (sample_data),
        .raddr (rd_nxt[ADDR_WIDTH:1]),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_waveform_to_pipe_bram.sv
// tb_waveform_to_pipe_bram: scoreboard bench for waveform_to_pipe_bram with a 4-word buffer
module tb_waveform_to_pipe_bram;
    localparam int AW = 2;
    logic          clk = 0, reset_n = 0, arm = 0, sample_valid = 0, pipe_out_read = 0;
    logic [31:0]   sample_data = '0;
    logic [7:0]    decim_ratio = '0;
    logic [15:0]   pipe_out_data;
    logic          ready, capturing;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   rd_addr;
    logic [15:0]   q[$];
    logic [15:0]   last_half;
    int            errors = 0, checks = 0;

    waveform_to_pipe_bram #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .sample_valid(sample_valid),
        .sample_data(sample_data), .pipe_out_read(pipe_out_read),
`ifdef WAVE_CAPTURE_DECIM_EN
        .decim_ratio(decim_ratio),
`endif
        .pipe_out_data(pipe_out_data), .ready(ready), .capturing(capturing),
        .wr_addr(wr_addr), .rd_addr(rd_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the stream is presented it must equal the queue head; a read pops it.
    always @(negedge clk) begin
        if (reset_n && ready) begin
            if (q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else begin
                chk("pipe_out_data", {16'h0, pipe_out_data}, {16'h0, q[0]});
                if (pipe_out_read) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        q.push_back(w[31:16]);
        q.push_back(w[15:0]);
        last_half = w[15:0];
    endtask

    task automatic capture(input logic [31:0] w0, w1, w2, w3, input bit do_arm, input bit gapped);
        logic [31:0] w[4];
        w = '{w0, w1, w2, w3};
        if (do_arm) begin
            arm = 1;
            step();
            arm = 0;
        end
        chk("capturing", {31'h0, capturing}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1;
            sample_data  = w[i];
            step();
            push_word(w[i]);
            chk("wr_addr_adv", {30'h0, wr_addr}, (i + 1) % 4);
            if (gapped && i < 3) begin
                sample_valid = 0;
                sample_data  = 32'hDEAD_BEEF;
                step();
                chk("wr_addr_gap", {30'h0, wr_addr}, (i + 1) % 4);
            end
        end
        sample_valid = 0;
        chk("ready_lat1", {31'h0, ready}, 32'd0);
        step();
        chk("ready_lat2", {31'h0, ready}, 32'd1);
    endtask

    task automatic drain(input int period);
        int k = 0;
        while (ready && k < 200) begin
            pipe_out_read = (k % period) == 0;
            step();
            k++;
        end
        pipe_out_read = 0;
        chk("drain_done", {31'h0, ready}, 32'd0);
        chk("sb_drained", q.size(), 32'd0);
        chk("hold_last", {16'h0, pipe_out_data}, {16'h0, last_half});
        chk("rd_wrap", {29'h0, rd_addr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) step();
        chk("rst_ready", {31'h0, ready}, 32'd0);
        chk("rst_capt", {31'h0, capturing}, 32'd0);
        chk("rst_wr", {30'h0, wr_addr}, 32'd0);
        chk("rst_rd", {29'h0, rd_addr}, 32'd0);
        chk("rst_data", {16'h0, pipe_out_data}, 32'd0);
        reset_n = 1;
        step();

        // basic capture, continuous drain: halves 0000..0007
        capture(32'h0000_0001, 32'h0002_0003, 32'h0004_0005, 32'h0006_0007, 1, 0);
        chk("first_half", {16'h0, pipe_out_data}, 32'h0000);
        drain(1);
        chk("basic_last", {16'h0, pipe_out_data}, 32'h0007);

        // reads and samples in IDLE are ignored
        pipe_out_read = 1;
        sample_valid  = 1;
        sample_data   = 32'h1234_5678;
        repeat (2) step();
        pipe_out_read = 0;
        sample_valid  = 0;
        chk("idle_rd", {29'h0, rd_addr}, 32'd0);
        chk("idle_wr", {30'h0, wr_addr}, 32'd0);
        chk("idle_capt", {31'h0, capturing}, 32'd0);
        chk("idle_hold", {16'h0, pipe_out_data}, 32'h0007);

        // gapped input, backpressured drain
        capture(32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4, 32'hD1D2_D3D4, 1, 1);
        drain(3);

        // re-arm after three halves read
        capture(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 1, 0);
        pipe_out_read = 1;
        repeat (3) step();
        pipe_out_read = 0;
        arm = 1;
        step();
        arm = 0;
        q.delete();
        chk("rearm_ready", {31'h0, ready}, 32'd0);
        chk("rearm_capt", {31'h0, capturing}, 32'd1);
        capture(32'h9999_AAAA, 32'hBBBB_CCCC, 32'hDDDD_EEEE, 32'hFFFF_0000, 0, 0);
        chk("rearm_first", {16'h0, pipe_out_data}, 32'h9999);

        // arm together with the final read: arm wins
        begin
            int n = 0;
            pipe_out_read = 1;
            while (q.size() > 1 && n < 50) begin
                step();
                n++;
            end
        end
        chk("pre_final_rd", {29'h0, rd_addr}, 32'd7);
        arm = 1;
        step();
        arm = 0;
        pipe_out_read = 0;
        chk("armwin_capt", {31'h0, capturing}, 32'd1);
        chk("armwin_ready", {31'h0, ready}, 32'd0);
        capture(32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10, 0, 0);
        drain(2);

        // async reset mid-capture
        arm = 1;
        step();
        arm = 0;
        sample_valid = 1;
        sample_data  = 32'hCAFE_F00D;
        repeat (2) step();
        #2 reset_n = 0;
        #1;
        sample_valid = 0;
        chk("mid_rst_capt", {31'h0, capturing}, 32'd0);
        chk("mid_rst_ready", {31'h0, ready}, 32'd0);
        chk("mid_rst_wr", {30'h0, wr_addr}, 32'd0);
        chk("mid_rst_data", {16'h0, pipe_out_data}, 32'd0);
        step();
        reset_n = 1;
        step();
        chk("post_rst_capt", {31'h0, capturing}, 32'd0);

`ifdef WAVE_CAPTURE_DECIM_EN
        // ratio 2: inputs 0..11 keep 0,3,6,9
        decim_ratio = 8'd2;
        arm = 1;
        step();
        arm = 0;
        decim_ratio = 8'd0;
        for (int i = 0; i < 12; i++) begin
            sample_valid = 1;
            sample_data  = i;
            step();
        end
        sample_valid = 0;
        push_word(32'd0);
        push_word(32'd3);
        push_word(32'd6);
        push_word(32'd9);
        begin
            int n = 0;
            while (!ready && n < 10) begin
                step();
                n++;
            end
        end
        chk("decim_ready", {31'h0, ready}, 32'd1);
        drain(1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
